clock_update_scheduler: RTL

Sequences every write to the clock's time and alarm registers. It arbitrates among the 1 Hz tick and the five debounced button pulses, then applies one wrap/carry-correct update per cycle. It also runs the alarm state machine, including ring timeout and optional snooze. It sits between the button debouncers and second divider upstream and the clock-face renderer and buzzer gate downstream, all in the `video_clk` domain.

---
 rtl/clock_update_scheduler_pkg.sv | 28 ++
 rtl/clock_update_scheduler_if.sv | 31 +++
 rtl/clock_update_scheduler_wrap_incrementer.sv | 32 +++
 rtl/clock_update_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/clock_update_scheduler_pkg.sv
// Shared types and constants for the clock update scheduler: alarm states,
// field widths/moduli and the grant indices that fix request priority.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    AL_OFF,
    AL_ARMED,
    AL_RINGING,
    AL_SNOOZED
  } alarm_state_e;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HRS_W   = 4;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HRS_MOD = 12;

  // Lower index wins arbitration.
  localparam int N_SRC  = 6;
  localparam int G_TICK = 0;
  localparam int G_SEC  = 1;
  localparam int G_MIN  = 2;
  localparam int G_HRS  = 3;
  localparam int G_AL   = 4;
  localparam int G_TOG  = 5;

endpackage

// File: rtl/clock_update_scheduler_if.sv
// Request pulses in, time/alarm/status out; master drives requests,
// slave is the scheduler.
interface clock_update_scheduler_if;
  import clock_ctrl_pkg::*;

  logic             tick_req;
  logic             sec_req;
  logic             min_req;
  logic             hrs_req;
  logic             al_req;
  logic             al_toggle_req;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic [HRS_W-1:0] hours;
  logic [MIN_W-1:0] al_minutes;
  logic [HRS_W-1:0] al_hours;
  logic             al_on;
  logic             ringing;
  logic             busy;

  modport master (
    output tick_req, sec_req, min_req, hrs_req, al_req, al_toggle_req,
    input  seconds, minutes, hours, al_minutes, al_hours, al_on, ringing, busy
  );

  modport slave (
    input  tick_req, sec_req, min_req, hrs_req, al_req, al_toggle_req,
    output seconds, minutes, hours, al_minutes, al_hours, al_on, ringing, busy
  );

endinterface

// File: rtl/clock_update_scheduler_wrap_incrementer.sv
// Adds STEP to a field when enabled, wrapping at MODULUS and flagging carry.
module wrap_incrementer #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60,
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);

  localparam logic [WIDTH:0] STEP_V = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_V  = (WIDTH+1)'(MODULUS);

  logic [WIDTH:0] sum;

  always_comb begin
    sum        = {1'b0, value} + STEP_V;
    next_value = value;
    carry      = 1'b0;
    if (en) begin
      if (sum >= MOD_V) begin
        next_value = WIDTH'(sum - MOD_V);
        carry      = 1'b1;
      end else begin
        next_value = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/clock_update_scheduler.sv
// Arbitrates tick/button requests into one time or alarm update per cycle
// and runs the alarm FSM. Optional snooze: define ALARM_SNOOZE_EN.
module clock_update_scheduler
  import clock_ctrl_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int AL_STEP        = 10
) (
  input  logic                     video_clk,
  input  logic                     reset_n,
  clock_update_scheduler_if.slave  bus
);

  localparam int RING_W = $clog2(RING_SECONDS + 1);

  logic [N_SRC-1:0] pending_q, pending_d, req_vec, grant;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d, al_min_q, al_min_d;
  logic [HRS_W-1:0] hrs_q, hrs_d, al_hrs_q, al_hrs_d;
  logic             sec_carry, min_carry, al_min_carry;
  logic             snooze_grab, alarm_hit;
  alarm_state_e     state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;

  assign req_vec = {bus.al_toggle_req, bus.al_req, bus.hrs_req,
                    bus.min_req, bus.sec_req, bus.tick_req};
  // Isolate the lowest set bit: index 0 (tick) has top priority.
  assign grant     = pending_q & (~pending_q + 1'b1);
  // A fresh pulse re-sets a bit being granted in the same cycle.
  assign pending_d = (pending_q & ~grant) | req_vec;

`ifdef ALARM_SNOOZE_EN
  localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
  localparam int SNZ_W        = $clog2(SNOOZE_TICKS + 1);
  logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_d;
  assign snooze_grab = grant[G_AL] && (state_q == AL_RINGING);
`else
  logic unused_snooze_cfg;
  assign unused_snooze_cfg = (SNOOZE_MINUTES != 0);
  assign snooze_grab       = 1'b0;
`endif

  logic hrs_carry_unused, al_hrs_carry_unused;

  wrap_incrementer #(.WIDTH(SEC_W), .MODULUS(SEC_MOD), .STEP(1)) u_sec (
    .value(sec_q), .en(grant[G_TICK] | grant[G_SEC]),
    .next_value(sec_d), .carry(sec_carry));
  wrap_incrementer #(.WIDTH(MIN_W), .MODULUS(MIN_MOD), .STEP(1)) u_min (
    .value(min_q), .en((grant[G_TICK] & sec_carry) | grant[G_MIN]),
    .next_value(min_d), .carry(min_carry));
  wrap_incrementer #(.WIDTH(HRS_W), .MODULUS(HRS_MOD), .STEP(1)) u_hrs (
    .value(hrs_q), .en((grant[G_TICK] & min_carry) | grant[G_HRS]),
    .next_value(hrs_d), .carry(hrs_carry_unused));
  wrap_incrementer #(.WIDTH(MIN_W), .MODULUS(MIN_MOD), .STEP(AL_STEP)) u_al_min (
    .value(al_min_q), .en(grant[G_AL] & ~snooze_grab),
    .next_value(al_min_d), .carry(al_min_carry));
  wrap_incrementer #(.WIDTH(HRS_W), .MODULUS(HRS_MOD), .STEP(1)) u_al_hrs (
    .value(al_hrs_q), .en(al_min_carry),
    .next_value(al_hrs_d), .carry(al_hrs_carry_unused));

  // Match on post-tick time so the alarm cannot re-fire within its minute.
  assign alarm_hit = (sec_d == '0) && (min_d == al_min_q) && (hrs_d == al_hrs_q);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    if (grant[G_TOG]) begin
      state_d    = (state_q == AL_OFF) ? AL_ARMED : AL_OFF;
      ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        AL_ARMED: begin
          if (grant[G_TICK] && alarm_hit) begin
            state_d    = AL_RINGING;
            ring_cnt_d = '0;
          end
        end
        AL_RINGING: begin
          if (grant[G_TICK]) begin
            if (ring_cnt_q == RING_W'(RING_SECONDS - 1)) begin
              state_d    = AL_ARMED;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q + 1'b1;
            end
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_grab) begin
            state_d      = AL_SNOOZED;
            snooze_cnt_d = SNZ_W'(SNOOZE_TICKS);
          end
`endif
        end
`ifdef ALARM_SNOOZE_EN
        AL_SNOOZED: begin
          if (grant[G_TICK]) begin
            if (snooze_cnt_q == SNZ_W'(1)) begin
              state_d      = AL_RINGING;
              ring_cnt_d   = '0;
              snooze_cnt_d = '0;
            end else begin
              snooze_cnt_d = snooze_cnt_q - 1'b1;
            end
          end
        end
`endif
        AL_OFF:  state_d = AL_OFF;
        default: state_d = AL_OFF;
      endcase
    end
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hrs_q      <= '0;
      al_min_q   <= '0;
      al_hrs_q   <= '0;
      state_q    <= AL_OFF;
      ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= '0;
`endif
    end else begin
      pending_q  <= pending_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hrs_q      <= hrs_d;
      al_min_q   <= al_min_d;
      al_hrs_q   <= al_hrs_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end

  logic unused_carries;
  assign unused_carries = hrs_carry_unused ^ al_hrs_carry_unused;

  assign bus.seconds    = sec_q;
  assign bus.minutes    = min_q;
  assign bus.hours      = hrs_q;
  assign bus.al_minutes = al_min_q;
  assign bus.al_hours   = al_hrs_q;
  assign bus.al_on      = (state_q != AL_OFF);
  assign bus.ringing    = (state_q == AL_RINGING);
  assign bus.busy       = |pending_q;

endmodule
